// File: rtl/mc_control_fsm_if.sv
// Control bus between the multicycle datapath and its controller.
// master: the controller (mc_control_fsm); slave: the datapath side.
interface mc_control_fsm_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic       IorD;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic [2:0] ALUControl;
  logic       PCEn;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    input  Op, Funct, Zero, MemReady,
    output IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, PCSrc, ALUControl, PCEn, Illegal, State
  );

  modport slave (
    output Op, Funct, Zero, MemReady,
    input  IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, PCSrc, ALUControl, PCEn, Illegal, State
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-style main controller with registered state-only outputs.
// Define MC_JUMP_EN to support the j instruction (Op 000010).
module mc_control_fsm (
  input logic              Clk,
  input logic              Rst,
  mc_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StAddiEx   = 4'd9,
    StAddiWb   = 4'd10,
    StJump     = 4'd11
  } state_e;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic       branch;
    logic       pc_write;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_ctrl;
  } outs_t;

  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  state_e r_state;
  state_e w_next;
  outs_t  r_outs;
  logic   w_illegal;
  logic   w_pc_write;
  logic [2:0] w_alu_ctrl;

  // Outputs that depend on the state alone, evaluated for the state being entered.
  function automatic outs_t state_outs(input state_e s);
    outs_t o;
    o          = '0;
    o.alu_ctrl = AluAdd;
    case (s)
      StFetch:    o.alu_src_b = 2'b01;
      StDecode:   o.alu_src_b = 2'b11;
      StMemAdr:   begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      StMemRead:  o.iord = 1'b1;
      StMemWb:    begin o.mem_to_reg = 1'b1; o.reg_write = 1'b1; end
      StMemWrite: begin o.iord = 1'b1; o.mem_write = 1'b1; end
      StExecute:  o.alu_src_a = 1'b1;
      StAluWb:    begin o.reg_dst = 1'b1; o.reg_write = 1'b1; end
      StBranch: begin
        o.alu_src_a = 1'b1;
        o.alu_ctrl  = AluSub;
        o.pc_src    = 2'b01;
        o.branch    = 1'b1;
      end
      StAddiEx:   begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      StAddiWb:   o.reg_write = 1'b1;
`ifdef MC_JUMP_EN
      StJump:     begin o.pc_src = 2'b10; o.pc_write = 1'b1; end
`endif
      default:    ;
    endcase
    return o;
  endfunction

  always_comb begin
    w_next    = StFetch;
    w_illegal = 1'b0;
    case (r_state)
      StFetch:   w_next = bus.MemReady ? StDecode : StFetch;
      StDecode: begin
        case (bus.Op)
          OpLw, OpSw: w_next = StMemAdr;
          OpRtype:    w_next = StExecute;
          OpBeq:      w_next = StBranch;
          OpAddi:     w_next = StAddiEx;
`ifdef MC_JUMP_EN
          OpJ:        w_next = StJump;
`endif
          default: begin
            w_next    = StFetch;
            w_illegal = 1'b1;
          end
        endcase
      end
      StMemAdr:   w_next = (bus.Op == OpSw) ? StMemWrite : StMemRead;
      StMemRead:  w_next = bus.MemReady ? StMemWb : StMemRead;
      StMemWrite: w_next = bus.MemReady ? StFetch : StMemWrite;
      StExecute:  w_next = StAluWb;
      StAddiEx:   w_next = StAddiWb;
      default:    w_next = StFetch;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= StFetch;
      r_outs  <= state_outs(StFetch);
    end else begin
      r_state <= w_next;
      r_outs  <= state_outs(w_next);
    end
  end

  always_comb begin
    w_alu_ctrl = r_outs.alu_ctrl;
    if (r_state == StExecute) begin
      case (bus.Funct)
        6'b100010: w_alu_ctrl = AluSub;
        6'b100100: w_alu_ctrl = AluAnd;
        6'b100101: w_alu_ctrl = AluOr;
        6'b101010: w_alu_ctrl = AluSlt;
        default:   w_alu_ctrl = AluAdd;
      endcase
    end
  end

  // FETCH loads IR and PC together, only once memory has returned the word.
  assign w_pc_write = r_outs.pc_write | ((r_state == StFetch) & bus.MemReady);

  assign bus.IorD       = r_outs.iord;
  assign bus.RegDst     = r_outs.reg_dst;
  assign bus.MemtoReg   = r_outs.mem_to_reg;
  assign bus.ALUSrcA    = r_outs.alu_src_a;
  assign bus.ALUSrcB    = r_outs.alu_src_b;
  assign bus.PCSrc      = r_outs.pc_src;
  assign bus.ALUControl = w_alu_ctrl;
  assign bus.State      = r_state;

  assign bus.IRWrite  = Rst & (r_state == StFetch) & bus.MemReady;
  assign bus.MemWrite = Rst & r_outs.mem_write;
  assign bus.RegWrite = Rst & r_outs.reg_write;
  assign bus.Illegal  = Rst & w_illegal;
  assign bus.PCEn     = Rst & (w_pc_write | (r_outs.branch & bus.Zero));

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized instruction stream against a per-instruction cycle-trace model,
// plus directed reset-abort checks.
module tb_mc_control_fsm;

`ifdef MC_JUMP_EN
  localparam bit JumpEn = 1'b1;
`else
  localparam bit JumpEn = 1'b0;
`endif

  localparam int KLw = 0, KSw = 1, KR = 2, KBeq = 3, KAddi = 4, KJ = 5, KBad = 6;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mc_control_fsm_if bus ();

  mc_control_fsm u_dut (
    .Clk (clk),
    .Rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st;
    bit mr;
  } cyc_t;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit op_legal(input logic [5:0] op);
    return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
           op == 6'b000100 || op == 6'b001000 || (JumpEn && op == 6'b000010);
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // {IorD,IRWrite,MemWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,PCSrc,ALUControl,PCEn,Illegal,State}
  function automatic logic [19:0] exp_vec(input int st, input bit mr, input logic [5:0] op,
                                          input logic [5:0] funct, input logic zero);
    logic iord = 0, irw = 0, mw = 0, rd = 0, m2r = 0, rw = 0, sa = 0, pcen = 0, ill = 0;
    logic [1:0] sb = 2'b00, pcs = 2'b00;
    logic [2:0] alu = 3'b010;
    case (st)
      0:  begin sb = 2'b01; irw = mr; pcen = mr; end
      1:  begin sb = 2'b11; ill = !op_legal(op); end
      2:  begin sa = 1; sb = 2'b10; end
      3:  iord = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin sa = 1; alu = funct_alu(funct); end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; alu = 3'b110; pcs = 2'b01; pcen = zero; end
      9:  begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin pcs = 2'b10; pcen = 1; end
      default: ;
    endcase
    return {iord, irw, mw, rd, m2r, rw, sa, sb, pcs, alu, pcen, ill, 4'(st)};
  endfunction

  function automatic logic [19:0] dut_vec();
    return {bus.IorD, bus.IRWrite, bus.MemWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite,
            bus.ALUSrcA, bus.ALUSrcB, bus.PCSrc, bus.ALUControl, bus.PCEn, bus.Illegal,
            bus.State};
  endfunction

  task automatic step(input int st, input bit mr, input logic [5:0] op,
                      input logic [5:0] funct, input logic zero);
    @(negedge clk);
    bus.Op       = op;
    bus.Funct    = funct;
    bus.Zero     = zero;
    bus.MemReady = mr;
    #1;
    check_eq($sformatf("outputs_st%0d_op%b", st, op), {12'd0, dut_vec()},
             {12'd0, exp_vec(st, mr, op, funct, zero)});
  endtask

  // A memory phase lasts one cycle plus one per cycle of MemReady low.
  function automatic void push_phase(ref cyc_t q[$], input int st, input int waits);
    for (int i = 0; i < waits; i++) q.push_back('{st: st, mr: 1'b0});
    q.push_back('{st: st, mr: 1'b1});
  endfunction

  function automatic void push_plain(ref cyc_t q[$], input int st);
    q.push_back('{st: st, mr: 1'($urandom_range(0, 1))});
  endfunction

  task automatic run_instr(input int kind, input int max_wait);
    cyc_t q[$];
    logic [5:0] op, funct;
    logic zero;
    funct = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 63))
          : ((kind == KR) ? 6'b100000 : 6'($urandom_range(0, 63)));
    if (kind == KR && $urandom_range(0, 1) == 1) begin
      case ($urandom_range(0, 4))
        0: funct = 6'b100000;
        1: funct = 6'b100010;
        2: funct = 6'b100100;
        3: funct = 6'b100101;
        default: funct = 6'b101010;
      endcase
    end
    zero = 1'($urandom_range(0, 1));
    case (kind)
      KLw:   op = 6'b100011;
      KSw:   op = 6'b101011;
      KR:    op = 6'b000000;
      KBeq:  op = 6'b000100;
      KAddi: op = 6'b001000;
      KJ:    op = 6'b000010;
      default: begin
        op = 6'($urandom_range(0, 63));
        while (op_legal(op)) op = 6'($urandom_range(0, 63));
      end
    endcase
    push_phase(q, 0, $urandom_range(0, max_wait));
    push_plain(q, 1);
    case (kind)
      KLw:   begin push_plain(q, 2); push_phase(q, 3, $urandom_range(0, max_wait));
                   push_plain(q, 4); end
      KSw:   begin push_plain(q, 2); push_phase(q, 5, $urandom_range(0, max_wait)); end
      KR:    begin push_plain(q, 6); push_plain(q, 7); end
      KBeq:  push_plain(q, 8);
      KAddi: begin push_plain(q, 9); push_plain(q, 10); end
      KJ:    if (JumpEn) push_plain(q, 11);
      default: ;
    endcase
    foreach (q[i]) step(q[i].st, q[i].mr, op, funct, zero);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_state"}, {28'd0, bus.State}, 32'd0);
    check_eq({tag, "_wen"}, {27'd0, bus.PCEn, bus.IRWrite, bus.MemWrite, bus.RegWrite,
             bus.Illegal}, 32'd0);
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.Op       = 6'b111111;
    bus.Funct    = 6'd0;
    bus.Zero     = 1'b1;
    bus.MemReady = 1'b1;
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    bus.MemReady = 1'b0;
    rst_n        = 1'b1;

    // Directed: each class with MemReady always ready, then with waits.
    for (int k = KLw; k <= KBad; k++) run_instr(k, 0);
    for (int k = KLw; k <= KBad; k++) run_instr(k, 2);

    // Abort an lw while it waits in MEMREAD.
    step(0, 1'b1, 6'b100011, 6'd0, 1'b0);
    step(1, 1'b0, 6'b100011, 6'd0, 1'b0);
    step(2, 1'b0, 6'b100011, 6'd0, 1'b0);
    step(3, 1'b0, 6'b100011, 6'd0, 1'b0);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.MemReady = 1'b1;
      #1 check_reset_outputs($sformatf("hold%0d", i));
    end
    bus.MemReady = 1'b0;
    rst_n        = 1'b1;
    run_instr(KLw, 0);

    for (int n = 0; n < 300; n++) run_instr($urandom_range(KLw, KBad), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 No parameters; all widths are fixed.
REQ-002 Clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Rst  in  1  asynchronous, active-low reset.
REQ-004 Op  in  6  instruction opcode, Instr[31:26], from the instruction register.
REQ-005 Funct  in  6  instruction funct field, Instr[5:0].
REQ-006 Zero  in  1  ALU zero flag.
REQ-007 MemReady  in  1  shared instruction/data memory has completed the current access.
REQ-008 IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA  out  1 each  datapath mux selects and write enables.
REQ-009 ALUSrcB  out  2  SrcB select: 00 reg, 01 const 4, 10 SignImm, 11 SignImm<<2.
REQ-010 PCSrc  out  2  next-PC select: 00 ALUResult, 01 ALUOut register, 10 PCJump.
REQ-011 ALUControl  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-012 PCEn  out  1  PC register load enable.
REQ-013 Illegal  out  1  one-cycle pulse when an unsupported opcode is decoded.
REQ-014 State  out  4  current state encoding, for debug and verification.

Function
REQ-015 State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
REQ-016 Codes 12-15 are unreachable; if one is entered, the next state shall be FETCH with all outputs at their defaults.
REQ-017 Output defaults in every state: all 1-bit outputs 0, ALUSrcB 00, PCSrc 00, ALUControl 010.
REQ-018 FETCH: IorD 0, ALUSrcA 0, ALUSrcB 01, IRWrite and PCWrite = MemReady; go to DECODE if MemReady, otherwise hold.
REQ-019 DECODE: ALUSrcA 0, ALUSrcB 11, add; next state by Op:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXECUTE
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - any other -> FETCH, with Illegal = 1 in this cycle.
REQ-020 MEMADR: ALUSrcA 1, ALUSrcB 10, add; go to MEMREAD for lw, MEMWRITE for sw.
REQ-021 MEMREAD: IorD 1; go to MEMWB if MemReady, otherwise hold.
REQ-022 MEMWB: RegDst 0, MemtoReg 1, RegWrite 1; go to FETCH.
REQ-023 MEMWRITE: IorD 1, MemWrite 1 held until MemReady; then go to FETCH.
REQ-024 EXECUTE: ALUSrcA 1, ALUSrcB 00; ALUControl by Funct:
  - 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111
  - any other Funct -> 010
  - then go to ALUWB.
REQ-025 ALUWB: RegDst 1, MemtoReg 0, RegWrite 1; go to FETCH.
REQ-026 BRANCH: ALUSrcA 1, ALUSrcB 00, sub, PCSrc 01, Branch internal 1; go to FETCH.
REQ-027 ADDIEX: ALUSrcA 1, ALUSrcB 10, add; go to ADDIWB.
REQ-028 ADDIWB: RegDst 0, MemtoReg 0, RegWrite 1; go to FETCH.
REQ-029 JUMP: PCSrc 10, PCWrite 1; go to FETCH.
REQ-030 PCEn = PCWrite OR (Branch AND Zero), combinational.
REQ-031 All outputs except ALUControl in EXECUTE, PCEn, IRWrite/PCWrite in FETCH, and Illegal in DECODE shall be a function of the state alone.
REQ-032 Latency with MemReady held at 1, in cycles:
  - lw 5; R-type, sw, addi 4; beq and j 3.
REQ-033 Each cycle MemReady is low extends FETCH, MEMREAD or MEMWRITE by exactly one cycle; no write enable is asserted twice for one instruction.

Reset
REQ-034 While Rst = 0, State shall be FETCH (0) asynchronously.
REQ-035 While Rst = 0, PCEn, IRWrite, MemWrite, RegWrite and Illegal shall be forced to 0.
REQ-036 Reset asserted mid-instruction aborts that instruction; the first rising Clk edge after Rst deasserts evaluates FETCH.

Configuration
REQ-037 Macro MC_JUMP_EN.
REQ-038 With MC_JUMP_EN defined, Op 000010 shall go to JUMP.
REQ-039 Without MC_JUMP_EN, Op 000010 shall be treated as illegal (FETCH, Illegal pulse), JUMP shall be unreachable, and PCSrc shall never be 10.

Verification
REQ-040 Reset with Rst low for 3 cycles mid-MEMREAD -> State 0, RegWrite 0, MemWrite 0; after release the sequence restarts at FETCH.
REQ-041 lw (Op 100011), MemReady 1 -> State 0,1,2,3,4 then 0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-042 R-type sub (Funct 100010) -> ALUControl 110 in EXECUTE; RegDst 1 and RegWrite 1 in ALUWB; 4 cycles total.
REQ-043 beq (Op 000100) with Zero 1 -> PCEn 1 and PCSrc 01 in BRANCH; with Zero 0 -> PCEn 0; 3 cycles.
REQ-044 sw with MemReady low for 2 cycles in MEMWRITE -> MemWrite held high 3 cycles, then FETCH; same instruction with MemReady low in FETCH -> IRWrite 0 until MemReady is 1.
REQ-045 Op 111111 -> Illegal pulses 1 cycle in DECODE, then FETCH; Op 000010 -> JUMP with PCSrc 10 if MC_JUMP_EN, otherwise an Illegal pulse.
